// File: rtl/arduino_uart_pkg.sv
// arduino_uart_pkg: shared frame constants and receiver state encodings for the Arduino command link.
package arduino_uart_pkg;
  localparam logic [4:0] HEADER = 5'd1;
  localparam int DEFAULT_CLKS_PER_BIT = 5209;
  localparam int DEFAULT_N = 13;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t STOP  = 3'd3;
  localparam state_t CHECK = 3'd4;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: generic 8N1 deserializer with a 2-flop input synchronizer, mid-bit sampling, LSB first.
module uart_rx
  import arduino_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int N = DEFAULT_N
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial,
  output logic [7:0] data,
  output logic       done,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [N-1:0] HALF = N'((CLKS_PER_BIT - 1) / 2);
  localparam logic [N-1:0] LAST = N'(CLKS_PER_BIT - 1);
  logic s1, s2, prev, armed;
  state_t state;
  logic [N-1:0] cnt;
  logic [2:0] idx;
  logic tick;
  assign tick = cnt == LAST;
  assign done = state == STOP && tick && s2;
  assign frame_err = state == STOP && tick && !s2;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      armed <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
    end else begin
      s1 <= serial;
      s2 <= s1;
      prev <= s2;
      case (state)
        IDLE: begin
          if (s2) armed <= 1'b1;
          if (armed && prev && !s2) begin
            cnt <= '0;
            state <= START;
          end
        end
        START: begin
          // a line that is high again at mid-start was a glitch
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= s2 ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (tick) begin
            cnt <= '0;
            data[idx] <= s2;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          // a low stop bit leaves the receiver disarmed until the line idles high
          if (tick) begin
            cnt <= '0;
            armed <= s2;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/arduino_uart_rx.sv
// arduino_uart_rx: 8N1 command receiver with header check and held 3-bit payload.
// Header compare is enabled by defining ARDUINO_RX_HEADER_CHECK_EN.
module arduino_uart_rx
  import arduino_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int N = DEFAULT_N
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_serial,
  output logic [2:0] Rx_data,
  output logic       Rx_valid,
  output logic       Rx_error,
  output logic       Rx_busy
);
`ifdef ARDUINO_RX_HEADER_CHECK_EN
  localparam logic [4:0] HDR_MASK = 5'h1f;
`else
  localparam logic [4:0] HDR_MASK = 5'h00;
`endif
  logic [7:0] rx_byte;
  logic done, frame_err, rx_busy, chk, hdr_ok;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .N(N)) u_rx (
    .clk(clk),
    .rst(rst),
    .serial(Rx_serial),
    .data(rx_byte),
    .done(done),
    .frame_err(frame_err),
    .busy(rx_busy)
  );
  assign hdr_ok = ((rx_byte[7:3] ^ HEADER) & HDR_MASK) == 5'd0;
  assign Rx_busy = rx_busy || chk;
  // chk marks the one-cycle CHECK phase in which the verdict is presented
  always_ff @(posedge clk) begin
    if (!rst) begin
      Rx_data <= '0;
      Rx_valid <= 1'b0;
      Rx_error <= 1'b0;
      chk <= 1'b0;
    end else begin
      chk <= done;
      Rx_valid <= done && hdr_ok;
      Rx_error <= frame_err || (done && !hdr_ok);
      if (done && hdr_ok) Rx_data <= rx_byte[2:0];
    end
  end
endmodule

// File: tb/tb_arduino_uart_rx.sv
// tb_arduino_uart_rx: scoreboard bench driving 8N1 frames at 16 clocks per bit.
module tb_arduino_uart_rx;
  localparam int CPB = 16;
  localparam int NW = 5;
  localparam int H = (CPB - 1) / 2;
  typedef struct packed {
    logic err;
    logic [2:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Rx_serial = 1'b1;
  logic [2:0] Rx_data;
  logic Rx_valid, Rx_error, Rx_busy;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t cur;
  logic [2:0] held = 3'd0;
  always #5 clk = ~clk;
  arduino_uart_rx #(.CLKS_PER_BIT(CPB), .N(NW)) dut (
    .clk(clk),
    .rst(rst),
    .Rx_serial(Rx_serial),
    .Rx_data(Rx_data),
    .Rx_valid(Rx_valid),
    .Rx_error(Rx_error),
    .Rx_busy(Rx_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic err, input logic [2:0] d);
    sb.push_back({err, d});
    if (!err) held = d;
  endtask
  task automatic drive_bit(input logic v);
    Rx_serial = v;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask
  always @(negedge clk) begin
    if (rst && (Rx_valid || Rx_error)) begin
      check("valid_error_exclusive", Rx_valid && Rx_error, 0);
      if (sb.size() == 0) check("unexpected_pulse", {Rx_valid, Rx_error}, 0);
      else begin
        cur = sb.pop_front();
        check("pulse_is_error", Rx_error, cur.err);
        check("pulse_data", Rx_data, cur.data);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int hi;
    repeat (3) @(negedge clk);
    check("rst_data", Rx_data, 0);
    check("rst_valid", Rx_valid, 0);
    check("rst_error", Rx_error, 0);
    check("rst_busy", Rx_busy, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    push(1'b0, 3'b101);
    send(8'h0D);
    repeat (CPB) @(negedge clk);
    check("c1_pending", sb.size(), 0);
    check("c1_busy", Rx_busy, 0);
    check("c1_data", Rx_data, 3'b101);
`ifdef ARDUINO_RX_HEADER_CHECK_EN
    push(1'b1, held);
`else
    push(1'b0, 3'b010);
`endif
    send(8'h2A);
    repeat (CPB) @(negedge clk);
    check("c2_pending", sb.size(), 0);
    check("c2_data", Rx_data, held);
    push(1'b1, held);
    send(8'h0B, 1'b0);
    hi = 0;
    repeat (2 * CPB) begin
      @(negedge clk);
      hi |= int'(Rx_busy);
    end
    check("c3_no_restart_while_low", hi, 0);
    Rx_serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("c3_pending", sb.size(), 0);
    check("c3_data", Rx_data, held);
    Rx_serial = 1'b0;
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      hi |= int'(Rx_busy);
    end
    Rx_serial = 1'b1;
    repeat (H + 1) begin
      @(negedge clk);
      hi |= int'(Rx_busy);
    end
    check("c4_glitch_seen_busy", hi, 1);
    check("c4_busy_cleared", Rx_busy, 0);
    repeat (2 * CPB) @(negedge clk);
    check("c4_data", Rx_data, held);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    Rx_serial = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("c5_rst_data", Rx_data, 0);
    check("c5_rst_valid", Rx_valid, 0);
    check("c5_rst_error", Rx_error, 0);
    check("c5_rst_busy", Rx_busy, 0);
    held = 3'd0;
    rst = 1'b1;
    Rx_serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    push(1'b0, 3'b111);
    send(8'h0F);
    repeat (CPB) @(negedge clk);
    check("c5_pending", sb.size(), 0);
    check("c5_data", Rx_data, 3'b111);
    push(1'b0, 3'b001);
    push(1'b0, 3'b110);
    send(8'h09);
    send(8'h0E);
    repeat (CPB) @(negedge clk);
    check("c6_pending", sb.size(), 0);
    check("c6_data", Rx_data, 3'b110);
    check("c6_busy", Rx_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
